scr1_tb_instr_class_mon: RTL

SCR1_TB_INSTR_CLASS_MON -- requirements
Module: scr1_tb_instr_class_mon

---
 rtl/scr1_tb_instr_class_mon.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/scr1_tb_instr_class_mon.sv
`default_nettype none
// ============================================================================
// Module  : scr1_tb_instr_class_mon
// Purpose : Instruction-class match monitor with per-channel hit counters and
//           a timestamped event FIFO. Optional pop/drop printing is enabled by
//           the macro SCR1_TB_INSTR_MON_DISPLAY_EN.
// Revision: 1.0 - initial release
// ============================================================================
module scr1_tb_instr_class_mon #(
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    resp_vld,
   input  logic [31:0]             instr,
   input  logic [31:0]             rs1_val,
   input  logic [31:0]             rs2_val,
   input  logic [NUM_CH-1:0]       ch_en,
   input  logic [NUM_CH*32-1:0]    ch_mask,
   input  logic [NUM_CH*32-1:0]    ch_match,
   output logic                    evt_valid,
   input  logic                    evt_ready,
   output logic [2:0]              evt_ch,
   output logic [31:0]             evt_instr,
   output logic [31:0]             evt_rs1,
   output logic [31:0]             evt_rs2,
   output logic [31:0]             evt_ts,
   output logic [NUM_CH*CNT_W-1:0] cnt,
   output logic [15:0]             drop_cnt,
   output logic                    ovf
);

   localparam int              AW      = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);

   logic [31:0]       ts;
   logic [NUM_CH-1:0] hit;
   logic              any_hit;
   logic [2:0]        win_ch;
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              fifo_empty;
   logic              fifo_full;
   logic              pop;
   logic              push;
   logic              drop;

   logic [2:0]        mem_ch    [FIFO_DEPTH];
   logic [31:0]       mem_instr [FIFO_DEPTH];
   logic [31:0]       mem_rs1   [FIFO_DEPTH];
   logic [31:0]       mem_rs2   [FIFO_DEPTH];
   logic [31:0]       mem_ts    [FIFO_DEPTH];

   // Channel match and per-channel saturating hit counters
   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         logic [CNT_W-1:0] cnt_q;

         assign hit[i] = resp_vld & ch_en[i] &
                         ((instr & ch_mask[32*i +: 32]) == ch_match[32*i +: 32]);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_q <= '0;
            end else if (clr) begin
               cnt_q <= '0;
            end else if (hit[i] && (cnt_q != CNT_MAX)) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end

         assign cnt[CNT_W*i +: CNT_W] = cnt_q;
      end
   endgenerate

   assign any_hit = |hit;

   // Lowest enabled hitting channel wins the FIFO entry
   always_comb begin
      win_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (hit[i]) begin
            win_ch = 3'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts <= '0;
      end else begin
         ts <= ts + 32'd1;
      end
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A same-cycle pop frees the slot, so a push into a full FIFO still lands
   assign pop  = ~fifo_empty & evt_ready & ~clr;
   assign push = any_hit & ~clr & (~fifo_full | pop);
   assign drop = any_hit & ~clr & fifo_full & ~pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_ch[wr_ptr[AW-1:0]]    <= win_ch;
         mem_instr[wr_ptr[AW-1:0]] <= instr;
         mem_rs1[wr_ptr[AW-1:0]]   <= rs1_val;
         mem_rs2[wr_ptr[AW-1:0]]   <= rs2_val;
         mem_ts[wr_ptr[AW-1:0]]    <= ts;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
         ovf      <= 1'b0;
      end else if (clr) begin
         drop_cnt <= '0;
         ovf      <= 1'b0;
      end else if (drop) begin
         if (drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
         ovf <= 1'b1;
      end
   end

   // Storage is not reset; gating the head with valid yields zeros when empty
   assign evt_valid = ~fifo_empty;
   assign evt_ch    = fifo_empty ? 3'd0  : mem_ch[rd_ptr[AW-1:0]];
   assign evt_instr = fifo_empty ? 32'd0 : mem_instr[rd_ptr[AW-1:0]];
   assign evt_rs1   = fifo_empty ? 32'd0 : mem_rs1[rd_ptr[AW-1:0]];
   assign evt_rs2   = fifo_empty ? 32'd0 : mem_rs2[rd_ptr[AW-1:0]];
   assign evt_ts    = fifo_empty ? 32'd0 : mem_ts[rd_ptr[AW-1:0]];

`ifdef SCR1_TB_INSTR_MON_DISPLAY_EN
   always @(posedge clk) begin
      if (!rst) begin
         if (pop) begin
            $display("ch=%0d ts=%0d instr=%08h rs1=%08h rs2=%08h",
                     evt_ch, evt_ts, evt_instr, evt_rs1, evt_rs2);
         end
         if (drop) begin
            $display("event dropped ts=%0d", ts);
         end
      end
   end
`else
   // Printing disabled: the monitor is purely synthesizable logic.
`endif

endmodule
`default_nettype wire
